// File: rtl/multicycle_control.sv
// multicycle_control
// Sequencer for a multi-cycle MIPS datapath (shared ALU, unified memory
// port, register file). Decodes every datapath select/strobe from the
// current state, waits on mem_ready in the memory-access states and
// counts retired instructions.
//
// Build option: MC_CTRL_ILLEGAL_TRAP_EN
//   defined   -> an unrecognized opcode parks the FSM in TRAP with the
//                sticky illegal flag set, until reset
//   undefined -> an unrecognized opcode retires as a NOP; illegal is 0
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct       IR[31:26] and IR[5:0]
//   zero                ALU zero flag (branch decision)
//   mem_ready           memory finishes the current access this cycle
//   pc_write .. alu_op  datapath strobes and mux selects
//   state               current state code (debug)
//   illegal             sticky illegal-opcode flag
//   instr_count         retired-instruction counter, wraps
//
// state     | meaning
// FETCH     | read IR from mem[PC], PC <= PC+1 when memory is ready
// DECODE    | branch target into ALUOut, pick instruction class
// MEM_ADDR  | base + offset for lw/sw
// MEM_READ  | lw data read, wait for mem_ready
// MEM_WB    | lw data into rt
// MEM_WRITE | sw data write, wait for mem_ready
// EXECUTE   | R-type ALU operation
// R_WB      | ALU result into rd
// BRANCH    | beq compare, PC <= target when zero
// JUMP      | j / jal (jal also links into r31)
// IMM_EXEC  | addi / lui / ori ALU operation
// IMM_WB    | ALU result into rt
// JR        | PC <= rs
// TRAP      | illegal opcode, halted until reset
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [2:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_JR        = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           cur;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic             ill_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= S_FETCH;
      op_q <= '0;
      cnt  <= '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ill_q <= 1'b0;
`endif
    end else begin
      case (cur)
        S_FETCH: if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          // IR is stable from here on; keep the opcode for the later steps
          op_q <= opcode;
          case (opcode)
            OP_LW, OP_SW: cur <= S_MEM_ADDR;
            OP_RTYPE:     cur <= (funct == FN_JR) ? S_JR : S_EXECUTE;
            OP_BEQ:       cur <= S_BRANCH;
            OP_J, OP_JAL: cur <= S_JUMP;
            OP_ADDI, OP_LUI, OP_ORI: cur <= S_IMM_EXEC;
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
              cur   <= S_TRAP;
              ill_q <= 1'b1;
`else
              cur <= S_FETCH;
              cnt <= cnt + 1'b1;
`endif
            end
          endcase
        end
        S_MEM_ADDR: cur <= (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ: if (mem_ready) cur <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) begin
          cur <= S_FETCH;
          cnt <= cnt + 1'b1;
        end
        S_EXECUTE:  cur <= S_R_WB;
        S_IMM_EXEC: cur <= S_IMM_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB, S_JR: begin
          cur <= S_FETCH;
          cnt <= cnt + 1'b1;
        end
        S_TRAP:  cur <= S_TRAP;
        default: cur <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_op     = 3'b000;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_source = 2'b01;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        if (op_q == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OP_LUI:  alu_op = 3'b011;
          OP_ORI:  alu_op = 3'b100;
          default: alu_op = 3'b000;
        endcase
      end
      S_IMM_WB: reg_write = 1'b1;
      S_JR: begin
        pc_source = 2'b11;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // reset must silence every side effect immediately, not one edge later
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state       = cur;
  assign instr_count = cnt;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write, alu_src_a;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_count;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    int unsigned cnt;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  // {pcw, irw, mr, mw, iord, rw, asa, rd, m2r, asb, ps, aop}
  function automatic logic [17:0] ctl(input logic pcw, irw, mr, mw, io, rw, asa,
                                      input logic [1:0] rd, m2r, asb, ps,
                                      input logic [2:0] aop);
    return {pcw, irw, mr, mw, io, rw, asa, rd, m2r, asb, ps, aop};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, fn, input logic z, rdy,
                     input logic [3:0] st, input logic [17:0] c,
                     input int unsigned cnt, input logic ill);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.st = st; v.ctl = c; v.cnt = cnt; v.ill = ill;
    vecs.push_back(v);
  endtask

  logic [17:0] c_f1, c_f0, c_dec, c_madr, c_mrd, c_mwb, c_mwr, c_ex, c_rwb;
  logic [17:0] c_br0, c_br1, c_j, c_jal, c_addi, c_lui, c_ori, c_iwb, c_jr, c_zero;

  // FETCH with memory ready, then DECODE (mem_ready low there: must be ignored)
  task automatic fd(input logic [5:0] op, fn, input int unsigned cnt);
    add(0, op, fn, 0, 1, 4'd0, c_f1, cnt, 0);
    add(0, op, fn, 0, 0, 4'd1, c_dec, cnt, 0);
  endtask

  initial begin
    c_f1   = ctl(1,1,1,0,0,0,0,2'b00,2'b00,2'b01,2'b00,3'b000);
    c_f0   = ctl(0,0,1,0,0,0,0,2'b00,2'b00,2'b01,2'b00,3'b000);
    c_dec  = ctl(0,0,0,0,0,0,0,2'b00,2'b00,2'b11,2'b00,3'b000);
    c_madr = ctl(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,2'b00,3'b000);
    c_mrd  = ctl(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000);
    c_mwb  = ctl(0,0,0,0,0,1,0,2'b00,2'b01,2'b00,2'b00,3'b000);
    c_mwr  = ctl(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000);
    c_ex   = ctl(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b010);
    c_rwb  = ctl(0,0,0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,3'b000);
    c_br0  = ctl(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b001);
    c_br1  = ctl(1,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b001);
    c_j    = ctl(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,3'b000);
    c_jal  = ctl(1,0,0,0,0,1,0,2'b10,2'b10,2'b00,2'b10,3'b000);
    c_addi = ctl(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,2'b00,3'b000);
    c_lui  = ctl(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,2'b00,3'b011);
    c_ori  = ctl(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,2'b00,3'b100);
    c_iwb  = ctl(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000);
    c_jr   = ctl(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b11,3'b000);
    c_zero = '0;

    // R-type add: 0,1,6,7
    fd(6'h00, 6'h20, 0);
    add(0, 6'h00, 6'h20, 0, 0, 4'd6, c_ex, 0, 0);
    add(0, 6'h00, 6'h20, 0, 1, 4'd7, c_rwb, 0, 0);
    // lw with two wait cycles in MEM_READ: 7 cycles
    fd(6'h23, 6'h00, 1);
    add(0, 6'h23, 6'h00, 0, 1, 4'd2, c_madr, 1, 0);
    add(0, 6'h23, 6'h00, 0, 0, 4'd3, c_mrd, 1, 0);
    add(0, 6'h23, 6'h00, 0, 0, 4'd3, c_mrd, 1, 0);
    add(0, 6'h23, 6'h00, 0, 1, 4'd3, c_mrd, 1, 0);
    add(0, 6'h23, 6'h00, 0, 0, 4'd4, c_mwb, 1, 0);
    // beq not taken, with one FETCH stall
    add(0, 6'h04, 6'h00, 0, 0, 4'd0, c_f0, 2, 0);
    fd(6'h04, 6'h00, 2);
    add(0, 6'h04, 6'h00, 0, 1, 4'd8, c_br0, 2, 0);
    // beq taken
    fd(6'h04, 6'h00, 3);
    add(0, 6'h04, 6'h00, 1, 0, 4'd8, c_br1, 3, 0);
    // jal, j, jr
    fd(6'h03, 6'h00, 4);
    add(0, 6'h03, 6'h00, 0, 0, 4'd9, c_jal, 4, 0);
    fd(6'h02, 6'h00, 5);
    add(0, 6'h02, 6'h00, 0, 1, 4'd9, c_j, 5, 0);
    fd(6'h00, 6'h08, 6);
    add(0, 6'h00, 6'h08, 0, 0, 4'd12, c_jr, 6, 0);
    // addi, lui, ori
    fd(6'h08, 6'h00, 7);
    add(0, 6'h08, 6'h00, 0, 0, 4'd10, c_addi, 7, 0);
    add(0, 6'h08, 6'h00, 0, 0, 4'd11, c_iwb, 7, 0);
    fd(6'h0F, 6'h00, 8);
    add(0, 6'h0F, 6'h00, 0, 1, 4'd10, c_lui, 8, 0);
    add(0, 6'h0F, 6'h00, 0, 1, 4'd11, c_iwb, 8, 0);
    fd(6'h0D, 6'h00, 9);
    add(0, 6'h0D, 6'h00, 0, 0, 4'd10, c_ori, 9, 0);
    add(0, 6'h0D, 6'h00, 0, 0, 4'd11, c_iwb, 9, 0);
    // sw, zero wait
    fd(6'h2B, 6'h00, 10);
    add(0, 6'h2B, 6'h00, 0, 0, 4'd2, c_madr, 10, 0);
    add(0, 6'h2B, 6'h00, 0, 1, 4'd5, c_mwr, 10, 0);
    // sw aborted by reset while stalled in MEM_WRITE
    fd(6'h2B, 6'h00, 11);
    add(0, 6'h2B, 6'h00, 0, 0, 4'd2, c_madr, 11, 0);
    add(0, 6'h2B, 6'h00, 0, 0, 4'd5, c_mwr, 11, 0);
    add(1, 6'h2B, 6'h00, 0, 0, 4'd5,
        ctl(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), 11, 0);
    // illegal opcode 111111
    fd(6'h3F, 6'h00, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    add(0, 6'h3F, 6'h00, 0, 1, 4'd13, c_zero, 0, 1);
    add(0, 6'h3F, 6'h00, 1, 1, 4'd13, c_zero, 0, 1);
    add(1, 6'h3F, 6'h00, 0, 1, 4'd13, c_zero, 0, 1);
    add(0, 6'h00, 6'h00, 0, 0, 4'd0, c_f0, 0, 0);
`else
    add(0, 6'h3F, 6'h00, 0, 0, 4'd0, c_f0, 1, 0);
    add(0, 6'h00, 6'h20, 0, 1, 4'd0, c_f1, 1, 0);
    add(0, 6'h00, 6'h20, 0, 0, 4'd1, c_dec, 1, 0);
`endif

    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      vec_t e, a;
      @(posedge clk);
      #1;
      reset = vecs[i].rst; opcode = vecs[i].op; funct = vecs[i].fn;
      zero = vecs[i].z; mem_ready = vecs[i].rdy;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      a.st  = state;
      a.ctl = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, alu_src_a,
               reg_dst, mem_to_reg, alu_src_b, pc_source, alu_op};
      a.ill = illegal;
      applied++;
      if (a.st !== e.st) begin
        miscompares++;
        $display("FAIL state vec %0d: got %0d want %0d", i, a.st, e.st);
      end
      if (a.ctl !== e.ctl) begin
        miscompares++;
        $display("FAIL ctl vec %0d (state %0d): got %b want %b", i, e.st, a.ctl, e.ctl);
      end
      if (instr_count !== e.cnt) begin
        miscompares++;
        $display("FAIL instr_count vec %0d: got %0d want %0d", i, instr_count, e.cnt);
      end
      if (a.ill !== e.ill) begin
        miscompares++;
        $display("FAIL illegal vec %0d: got %b want %b", i, a.ill, e.ill);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state sequencer that drives the shared MIPS datapath in multi-cycle mode: one ALU, one unified memory port and the register file, reused across FETCH/DECODE/EXECUTE/MEM/WB steps. It replaces the single-cycle opcode decoder, emits every datapath select/strobe per cycle, waits on a memory ready handshake, and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0]; used only in DECODE.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `iord`, `reg_write`, `alu_src_a`  out  1 each  datapath strobes/selects.
- `reg_dst`, `mem_to_reg`, `alu_src_b`, `pc_source`  out  2 each  mux selects.
- `alu_op`  out  3  000 add, 001 sub, 010 R-type funct, 011 lui, 100 ori.
- `state`  out  4  current state code (debug).
- `illegal`  out  1  sticky illegal-opcode flag (see Configuration).
- `instr_count`  out  CNT_W  retired instructions.

## Operation
- States/codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11, JR 12, TRAP 13.
- Outputs not listed for a state are 0.
- FETCH: mem_read=1, iord=0, alu_src_b=01 (constant 1, word-addressed PC), alu_op=000, pc_source=00; ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_b=11, alu_op=000 (branch target to ALUOut); latch opcode (and jr flag) internally. Next: 100011/101011 -> MEM_ADDR; 000000 with funct 001000 -> JR; other 000000 -> EXECUTE; 000100 -> BRANCH; 000010/000011 -> JUMP; 001000/001111/001101 -> IMM_EXEC; anything else -> Configuration.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, iord=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01.
- MEM_WRITE: mem_write=1, iord=1; hold until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=010; -> R_WB. R_WB: reg_write=1, reg_dst=01, mem_to_reg=00.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, pc_write=zero.
- JUMP: pc_source=10, pc_write=1; for jal also reg_write=1, reg_dst=10, mem_to_reg=10.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op 000 (addi)/011 (lui)/100 (ori) from latched opcode; -> IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00.
- JR: pc_source=11, pc_write=1.
- MEM_WB, MEM_WRITE(on ready), R_WB, BRANCH, JUMP, IMM_WB, JR return to FETCH; instr_count +1 on that transition, wraps modulo 2^CNT_W.

## Timing
- Reset: next edge state=FETCH, instr_count=0, illegal=0; while reset is high all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) forced 0. Reset mid-instruction aborts with no further strobes.
- State is registered; outputs decode from state, latched opcode, and (pc_write/ir_write in FETCH, pc_write in BRANCH) same-cycle mem_ready/zero.
- Zero-wait cycles: beq/j/jal/jr 3, R-type/addi/lui/ori/sw 4, lw 5. Each low mem_ready cycle in FETCH/MEM_READ/MEM_WRITE adds one.
- mem_ready outside memory states is ignored. mem_ready held low stalls indefinitely, strobes held steady.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined: unrecognized opcode -> TRAP; TRAP holds forever with all strobes 0, illegal=1 until reset; not counted.
- Undefined: unrecognized opcode treated as NOP: DECODE -> FETCH, counted as retired; illegal tied 0.

## Test plan
- Reset then R-type add, mem_ready=1 -> states 0,1,6,7,0; R_WB reg_write=1 reg_dst=01; instr_count=1.
- lw with mem_ready low 2 cycles in MEM_READ -> 7 cycles total, mem_read=iord=1 held, one MEM_WB reg_write pulse, mem_to_reg=01.
- beq with zero=0 then zero=1 -> BRANCH pc_write 0 then 1 with pc_source=01, alu_op=001.
- jal -> JUMP: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; jr (000000/001000) -> JR pc_source=11.
- Reset asserted in MEM_WRITE while mem_ready=0 -> next cycle FETCH, instr_count=0, mem_write=0 during reset.
- Opcode 111111: with macro state=13, illegal=1, count unchanged; without macro back to FETCH, count +1.
